// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: state encoding and default widths.
package reg_dump_reader_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_reader_out_stage.sv
// Output holding register for the dump stream: load a word, hold it under backpressure, clear on handshake/abort.
module reg_dump_out_stage
    import reg_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_last,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_last;

    // Payload is only ever replaced by a load, so a stalled word is immune to later register-file writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_addr  <= i_addr;
            r_last  <= i_last;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_last  = r_last;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks register addresses 0..NUM_REGS-1 through a shared read port and streams each word over valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    input  logic [DATA_WIDTH-1:0] RF_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [ADDR_WIDTH-1:0] OUT_ADDR,
    output logic                  OUT_LAST,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_done;
    logic                  w_hs;
    logic                  w_load;
    logic                  w_clr;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic                  w_done_set;
    logic                  w_ld_last;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [ADDR_WIDTH-1:0] w_ld_addr;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_acc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_acc <= '0;
        end else if (r_state == ST_IDLE && START) begin
            r_acc <= '0;
        end else if (r_state == ST_READ && !ABORT) begin
            r_acc <= r_acc ^ RF_DATA;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter only advances below LAST_IDX, so it can never wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done_set  = 1'b0;
        w_ld_data   = RF_DATA;
        w_ld_addr   = r_cnt;
        w_hs        = OUT_VALID && OUT_READY;
`ifdef REG_DUMP_CHECKSUM_EN
        w_ld_last   = 1'b0;
`else
        w_ld_last   = (r_cnt == LAST_IDX);
`endif
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_READ;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_READ: begin
                if (ABORT) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ABORT) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end else if (w_hs) begin
                    if (r_cnt != LAST_IDX) begin
                        w_cnt_inc   = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        w_load      = 1'b1;
                        w_ld_data   = r_acc;
                        w_ld_addr   = '0;
                        w_ld_last   = 1'b1;
                        w_state_nxt = ST_CSUM;
`else
                        w_clr       = 1'b1;
                        w_done_set  = 1'b1;
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (ABORT) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end else if (w_hs) begin
                    w_clr       = 1'b1;
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    reg_dump_out_stage #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_load  (w_load),
        .i_clr   (w_clr),
        .i_data  (w_ld_data),
        .i_addr  (w_ld_addr),
        .i_last  (w_ld_last),
        .o_valid (OUT_VALID),
        .o_data  (OUT_DATA),
        .o_addr  (OUT_ADDR),
        .o_last  (OUT_LAST)
    );

    assign RF_ADDR = r_cnt;
    assign BUSY    = (r_state != ST_IDLE);
    assign DONE    = r_done;

endmodule
